// File: rtl/systolic_sequencer.sv
// systolic_sequencer: control FSM for the 3x3 weight-stationary systolic datapath.
// Preloads the weights (unless reusable), then runs four feature passes, one per
// 2x2 output tile, waiting for loader done flags plus a fixed drain interval.
// Optional feature: define SYSSEQ_WATCHDOG_EN to add a per-phase load watchdog
// that moves the sequencer to a sticky ERR state on timeout.
module systolic_sequencer #(
    parameter int FEAT_BASE      = 9,
    parameter int IMG_W          = 4,
    parameter int DRAIN_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       skip_weights,
    input  logic       is_WL_done,
    input  logic       is_FL_done,
    output logic       weight_preloader_en,
    output logic       feature_loader_en,
    output logic [5:0] feature_baseaddr,
    output logic       mode,
    output logic [1:0] c_sel,
    output logic       busy,
    output logic       done,
    output logic       tile_valid,
    output logic [1:0] tile_idx,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_F, S_DRAIN, S_DONE, S_ERR
    } state_t;

    localparam logic [5:0] FB6 = 6'(FEAT_BASE);
    localparam logic [5:0] IW6 = 6'(IMG_W);
    localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

    state_t     state, state_nxt;
    logic [1:0] tile, tile_nxt;
    logic [3:0] drain_cnt, drain_nxt;
    logic       weights_loaded, wl_nxt;
    logic       wd_timeout;

    // next-cycle values of the registered outputs
    logic       wp_en_d, fl_en_d, mode_d, busy_d, done_d, tv_d, err_d;
    logic [5:0] addr_d;
    logic [1:0] c_sel_d;

`ifdef SYSSEQ_WATCHDOG_EN
    logic [6:0] wd_cnt;

    // watchdog: restart on every phase change, count cycles spent waiting in a load phase
    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt <= '0;
        else if (state_nxt != state)
            wd_cnt <= '0;
        else if (state == S_LOAD_W || state == S_LOAD_F)
            wd_cnt <= wd_cnt + 7'd1;
    end

    assign wd_timeout = (wd_cnt == 7'(TIMEOUT_CYCLES - 1));
`else
    assign wd_timeout = 1'b0;
`endif

    // state register plus tile, drain counter and weight-reuse flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            tile           <= '0;
            drain_cnt      <= '0;
            weights_loaded <= 1'b0;
        end else begin
            state          <= state_nxt;
            tile           <= tile_nxt;
            drain_cnt      <= drain_nxt;
            weights_loaded <= wl_nxt;
        end
    end

    // next-state logic; done flags only matter in their own load state
    always_comb begin
        state_nxt = state;
        tile_nxt  = tile;
        drain_nxt = drain_cnt;
        wl_nxt    = weights_loaded;
        case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    tile_nxt  = 2'd0;
                    state_nxt = (skip_weights && weights_loaded) ? S_LOAD_F : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (is_WL_done) begin
                    wl_nxt    = 1'b1;
                    state_nxt = S_LOAD_F;
                end else if (wd_timeout) begin
                    state_nxt = S_ERR;
                end
            end
            S_LOAD_F: begin
                if (is_FL_done) begin
                    drain_nxt = DRAIN_LD;
                    state_nxt = S_DRAIN;
                end else if (wd_timeout) begin
                    state_nxt = S_ERR;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == 4'd0) begin
                    if (tile == 2'd3) begin
                        state_nxt = S_DONE;
                    end else begin
                        tile_nxt  = tile + 2'd1;
                        state_nxt = S_LOAD_F;
                    end
                end else begin
                    drain_nxt = drain_cnt - 4'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // a retry after a fault must never trust the old weights
        if (state_nxt == S_ERR)
            wl_nxt = 1'b0;
    end

    // output decode from the next state so every output comes straight off a flop
    always_comb begin
        wp_en_d = (state_nxt == S_LOAD_W);
        fl_en_d = (state_nxt == S_LOAD_F);
        mode_d  = (state_nxt == S_LOAD_F) || (state_nxt == S_DRAIN);
        busy_d  = (state_nxt != S_IDLE) && (state_nxt != S_ERR);
        done_d  = (state_nxt == S_DONE);
        tv_d    = (state_nxt == S_DRAIN) && (drain_nxt == 4'd0);
        c_sel_d = c_sel;
        addr_d  = feature_baseaddr;
        if (state_nxt == S_LOAD_F) begin
            c_sel_d = tile_nxt;
            addr_d  = FB6 + (tile_nxt[1] ? IW6 : 6'd0) + {5'd0, tile_nxt[0]};
        end
`ifdef SYSSEQ_WATCHDOG_EN
        err_d = (state_nxt == S_ERR);
`else
        err_d = 1'b0;
`endif
    end

    // output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            weight_preloader_en <= 1'b0;
            feature_loader_en   <= 1'b0;
            feature_baseaddr    <= '0;
            mode                <= 1'b0;
            c_sel               <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            tile_valid          <= 1'b0;
            err                 <= 1'b0;
        end else begin
            weight_preloader_en <= wp_en_d;
            feature_loader_en   <= fl_en_d;
            feature_baseaddr    <= addr_d;
            mode                <= mode_d;
            c_sel               <= c_sel_d;
            busy                <= busy_d;
            done                <= done_d;
            tile_valid          <= tv_d;
            err                 <= err_d;
        end
    end

    // tile is itself a register, so the index output is registered as well
    assign tile_idx = tile;

endmodule
